// File: rtl/trig_scheduler.sv
// trig_scheduler: frame-synchronous scheduler sharing one sin/cos ROM among
// N_REQ requesters. Each frame_clk rising edge snapshots all angles, then
// issues one ROM lookup per requester and latches the returned sin/cos words.
module trig_scheduler #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned ANGLE_W   = 6,
  parameter int unsigned ANGLE_MAX = 44,
  parameter int unsigned ROM_LAT   = 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     frame_clk,
  input  logic [N_REQ*ANGLE_W-1:0] angle_in,
  output logic [ANGLE_W-1:0]       rom_addr,
  output logic                     rom_rd,
  input  logic [7:0]               rom_sin,
  input  logic [7:0]               rom_cos,
  output logic [N_REQ*8-1:0]       sin_out,
  output logic [N_REQ*8-1:0]       cos_out,
  output logic [N_REQ-1:0]         valid,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun,
  output logic                     range_err
);

  localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned SNAP_W = N_REQ * ANGLE_W;
  localparam int unsigned DATA_W = N_REQ * 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SNAP    = 3'd1,
    LOOKUP  = 3'd2,
    WAIT    = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          sync_q;
  logic                fprev_q;
  logic                frame_edge_c;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    wait_q, wait_d;
  logic [SNAP_W-1:0]   snap_q, snap_d;
  logic [DATA_W-1:0]   sin_q, sin_d;
  logic [DATA_W-1:0]   cos_q, cos_d;
  logic [N_REQ-1:0]    valid_q, valid_d;
  logic [ANGLE_W-1:0]  addr_q, addr_d;
  logic [ANGLE_W-1:0]  lk_angle;
  logic                rd_q, rd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;
  logic                rerr_q, rerr_d;

  // Rising edge of the synchronized frame strobe.
  assign frame_edge_c = sync_q[1] & ~fprev_q;

  // Frame strobe synchronizer; reset high so a level already high at release is not an edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_q  <= 2'b11;
      fprev_q <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], frame_clk};
      fprev_q <= sync_q[1];
    end
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wait_q  <= '0;
      snap_q  <= '0;
      sin_q   <= '0;
      cos_q   <= '0;
      valid_q <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      snap_q  <= snap_d;
      sin_q   <= sin_d;
      cos_q   <= cos_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      rerr_q  <= rerr_d;
    end
  end

  // Next-state logic; ROM strobe/address are derived from the next state so they register in step.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wait_d   = wait_q;
    snap_d   = snap_q;
    sin_d    = sin_q;
    cos_d    = cos_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    rd_d     = 1'b0;
    rerr_d   = rerr_q;
    ovr_d    = ovr_q | (frame_edge_c & (state_q != IDLE));
    lk_angle = '0;

    case (state_q)
      IDLE: begin
        if (frame_edge_c) state_d = SNAP;
      end
      SNAP: begin
        snap_d  = angle_in;
        valid_d = '0;
        idx_d   = '0;
        state_d = LOOKUP;
      end
      LOOKUP: begin
        wait_d = CNT_W'(ROM_LAT - 1);
        if (ROM_LAT > 1) state_d = WAIT;
        else             state_d = CAPTURE;
      end
      WAIT: begin
        if (wait_q <= CNT_W'(1)) state_d = CAPTURE;
        else                     wait_d  = wait_q - CNT_W'(1);
      end
      CAPTURE: begin
        sin_d[idx_q*8 +: 8] = rom_sin;
        cos_d[idx_q*8 +: 8] = rom_cos;
        valid_d[idx_q]      = 1'b1;
        if (idx_q == IDX_W'(N_REQ - 1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = LOOKUP;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == LOOKUP) begin
      rd_d     = 1'b1;
      lk_angle = snap_d[idx_d*ANGLE_W +: ANGLE_W];
      if (32'(lk_angle) > ANGLE_MAX) begin
        addr_d = '0;
        rerr_d = 1'b1;
      end else begin
        addr_d = lk_angle;
      end
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign rom_addr  = addr_q;
  assign rom_rd    = rd_q;
  assign sin_out   = sin_q;
  assign cos_out   = cos_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = ovr_q;
  assign range_err = rerr_q;

endmodule
